// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a byte FIFO, a status register and parameterised framing.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_tx_fifo #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   output logic        serialOut
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic                 rdy;
   logic                 overflow;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

   logic                 full;
   logic                 empty;
   logic                 wr_data;
   logic                 wr_status;
   logic                 push;
   logic                 pop;
   logic                 load;
   logic                 idle;
   logic [8:0]           count_ext;
   logic [31:0]          status;

   state_t               state,   state_n;
   logic [15:0]          timer,   timer_n;
   logic [2:0]           bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shreg,   shreg_n;
   logic                 serial_q, serial_n;
   logic                 par_q,   par_n;
   logic                 unused_inputs;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign wr_data   = rdy & mem_wstrb[0] & ~mem_addr[2];
   assign wr_status = rdy & mem_wstrb[0] & mem_addr[2];
   assign push      = wr_data & ~full;
   assign idle      = (state == IDLE) & empty;
   assign count_ext = 9'(count);
   assign status    = {16'b0, count_ext[7:0], 4'b0, overflow, idle, empty, ~full};

   assign mem_ready = enable ? rdy    : 1'bz;
   assign mem_rdata = enable ? status : 32'bz;
   assign serialOut = serial_q;

   assign unused_inputs = ^{mem_instr, mem_wstrb[3:1], mem_wdata, mem_addr, count_ext[8],
                            (PARITY_ODD != 0)};

   // Bus ack, FIFO pointers and the sticky overflow flag; full is judged before any same-cycle pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdy      <= 1'b0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         rdy <= mem_valid & enable & ~rdy;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW + 1)'(1);
         else if (pop && !push)
            count <= count - (AW + 1)'(1);
         if (wr_status)
            overflow <= 1'b0;
         else if (wr_data && full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_wdata[DATA_BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         serial_q <= 1'b1;
         par_q    <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         serial_q <= serial_n;
         par_q    <= par_n;
      end
   end

   // Every bit reloads the timer; a frame start is shared by IDLE and the end of STOP.
   always_comb begin
      state_n   = state;
      timer_n   = timer;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      serial_n  = serial_q;
      par_n     = par_q;
      pop       = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty)
               load = 1'b1;
         end
         START: begin
            if (timer == '0) begin
               state_n   = DATA;
               timer_n   = DIV_LAST;
               bit_idx_n = '0;
               serial_n  = shreg[0];
               shreg_n   = shreg >> 1;
            end else begin
               timer_n = timer - 16'd1;
            end
         end
         DATA: begin
            if (timer == '0) begin
               timer_n = DIV_LAST;
               if (bit_idx == DATA_LAST) begin
                  bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n  = PARITY;
                  serial_n = par_q;
`else
                  state_n  = STOP;
                  serial_n = 1'b1;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  serial_n  = shreg[0];
                  shreg_n   = shreg >> 1;
               end
            end else begin
               timer_n = timer - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (timer == '0) begin
               state_n   = STOP;
               timer_n   = DIV_LAST;
               bit_idx_n = '0;
               serial_n  = 1'b1;
            end else begin
               timer_n = timer - 16'd1;
            end
         end
`endif
         STOP: begin
            if (timer == '0) begin
               if (bit_idx == STOP_LAST) begin
                  if (!empty)
                     load = 1'b1;
                  else
                     state_n = IDLE;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  timer_n   = DIV_LAST;
               end
            end else begin
               timer_n = timer - 16'd1;
            end
         end
         default: begin
            state_n  = IDLE;
            timer_n  = '0;
            serial_n = 1'b1;
         end
      endcase
      if (load) begin
         pop      = 1'b1;
         shreg_n  = fifo_mem[rd_ptr];
         serial_n = 1'b0;
         state_n  = START;
         timer_n  = DIV_LAST;
`ifdef UART_TX_PARITY_EN
         par_n = (PARITY_ODD != 0) ? ~^fifo_mem[rd_ptr] : ^fifo_mem[rd_ptr];
`endif
      end
   end

endmodule
